// File: rtl/friscv_gpio_responder_if.sv
// Slave-side memory request/response bundle used by the GPIO responder.
// The master holds slv_en until slv_ready; slv_rdata is meaningful only while slv_ready=1.
interface friscv_gpio_responder_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned XLEN  = 32
);
  logic              slv_en;
  logic              slv_wr;
  logic [ADDRW-1:0]  slv_addr;
  logic [XLEN-1:0]   slv_wdata;
  logic [XLEN/8-1:0] slv_strb;
  logic [XLEN-1:0]   slv_rdata;
  logic              slv_ready;

  modport master (
    output slv_en, slv_wr, slv_addr, slv_wdata, slv_strb,
    input  slv_rdata, slv_ready
  );

  modport slave (
    input  slv_en, slv_wr, slv_addr, slv_wdata, slv_strb,
    output slv_rdata, slv_ready
  );
endinterface

// File: rtl/friscv_gpio_responder.sv
// GPIO register bank (OUT, OE, IN, RISE) behind a fixed-latency slave port.
// Each accepted request yields one registered ready pulse LATENCY cycles after acceptance.
module friscv_gpio_responder #(
  parameter int unsigned ADDRW          = 16,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned GPIO_BASE_ADDR = 0,
  parameter int unsigned LATENCY        = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          srst,
  friscv_gpio_responder_if.slave        slv,
  input  logic [XLEN-1:0]               gpio_in,
  output logic [XLEN-1:0]               gpio_out,
  output logic [XLEN-1:0]               gpio_oe
);

  localparam logic [ADDRW-1:0] Base  = ADDRW'(GPIO_BASE_ADDR);
  localparam logic [3:0]       LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_wr_q;
  logic [ADDRW-1:0]  req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [XLEN/8-1:0] req_strb_q;
  logic [XLEN-1:0]   rdata_q;
  logic              ready_q;

  logic [XLEN-1:0]   out_q, out_d, oe_q, oe_d, rise_q, rise_d;
  logic [XLEN-1:0]   sync1_q, sync2_q, prev_q;

  logic [ADDRW-1:0]  rd_addr;
  logic [2:0]        rd_dec, wr_dec;
  logic [XLEN-1:0]   rd_val, wmask, clr;
  logic              do_wr;

  // Returns {hit, word index}; anything outside the 16-byte window misses.
  function automatic logic [2:0] dec(input logic [ADDRW-1:0] a);
    logic [ADDRW-1:0] o;
    o   = a - Base;
    dec = {(a >= Base) && (o < ADDRW'(16)), o[3:2]};
  endfunction

  // Reads are sampled on the edge that enters RESP: live address when LATENCY=1.
  always_comb begin
    rd_addr = (state_q == StIdle) ? slv.slv_addr : req_addr_q;
    rd_dec  = dec(rd_addr);
    rd_val  = '0;
    if (rd_dec[2]) begin
      unique case (rd_dec[1:0])
        2'd0: rd_val = out_q;
        2'd1: rd_val = oe_q;
        2'd2: rd_val = sync2_q;
        2'd3: rd_val = rise_q;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < XLEN / 8; k++) begin
      wmask[8*k +: 8] = {8{req_strb_q[k]}};
    end
    wr_dec = dec(req_addr_q);
    do_wr  = (state_q == StResp) && req_wr_q && wr_dec[2];
    out_d  = out_q;
    oe_d   = oe_q;
    clr    = '0;
    if (do_wr && wr_dec[1:0] == 2'd0) out_d = (out_q & ~wmask) | (req_wdata_q & wmask);
    if (do_wr && wr_dec[1:0] == 2'd1) oe_d = (oe_q & ~wmask) | (req_wdata_q & wmask);
    if (do_wr && wr_dec[1:0] == 2'd3) clr = req_wdata_q & wmask;
    // A new rising edge beats a simultaneous write-1-to-clear.
    rise_d = (rise_q & ~clr) | (sync2_q & ~prev_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      {sync1_q, sync2_q, prev_q} <= '0;
      {out_q, oe_q, rise_q}      <= '0;
    end else if (srst) begin
      {sync1_q, sync2_q, prev_q} <= '0;
      {out_q, oe_q, rise_q}      <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      out_q   <= out_d;
      oe_q    <= oe_d;
      rise_q  <= rise_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else if (srst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        StIdle: begin
          if (slv.slv_en) begin
            req_wr_q    <= slv.slv_wr;
            req_addr_q  <= slv.slv_addr;
            req_wdata_q <= slv.slv_wdata;
            req_strb_q  <= slv.slv_strb;
            cnt_q       <= LatM1;
            if (LATENCY == 1) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              rdata_q <= slv.slv_wr ? '0 : rd_val;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            rdata_q <= req_wr_q ? '0 : rd_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slv.slv_ready = ready_q;
  assign slv.slv_rdata = rdata_q;
  assign gpio_out      = out_q;
  assign gpio_oe       = oe_q;

endmodule

// File: tb/tb_friscv_gpio_responder.sv
// Bench for friscv_gpio_responder: a LATENCY=3 instance at base 0x100 and a LATENCY=1 instance
// at base 0; read data is checked against a per-instance queue of expected responses.
module tb_friscv_gpio_responder;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn3, aresetn1, srst3, srst1;
  logic [31:0] gpio_in3, gpio_in1;
  logic [31:0] gpio_out3, gpio_oe3, gpio_out1, gpio_oe1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q3[$];
  exp_t q1[$];
  exp_t e3, e1;

  friscv_gpio_responder_if #(.ADDRW(16), .XLEN(32)) b3 ();
  friscv_gpio_responder_if #(.ADDRW(16), .XLEN(32)) b1 ();

  friscv_gpio_responder #(
    .ADDRW(16), .XLEN(32), .GPIO_BASE_ADDR(32'h100), .LATENCY(3)
  ) dut3 (
    .aclk(aclk), .aresetn(aresetn3), .srst(srst3), .slv(b3),
    .gpio_in(gpio_in3), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3)
  );

  friscv_gpio_responder #(
    .ADDRW(16), .XLEN(32), .GPIO_BASE_ADDR(0), .LATENCY(1)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn1), .srst(srst1), .slv(b1),
    .gpio_in(gpio_in1), .gpio_out(gpio_out1), .gpio_oe(gpio_oe1)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every ready pulse must match the oldest outstanding request.
  always @(negedge aclk) begin
    if (b3.slv_ready) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL dut3_unexpected_ready: ready=1 required no pulse");
      end else begin
        e3 = q3.pop_front();
        if (e3.chk && b3.slv_rdata !== e3.data) begin
          n_err++;
          $display("FAIL dut3_rdata: got %h required %h", b3.slv_rdata, e3.data);
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (b1.slv_ready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected_ready: ready=1 required no pulse");
      end else begin
        e1 = q1.pop_front();
        if (e1.chk && b1.slv_rdata !== e1.data) begin
          n_err++;
          $display("FAIL dut1_rdata: got %h required %h", b1.slv_rdata, e1.data);
        end
      end
    end
  end

  task automatic m3_req(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rd,
                        output int lat, output logic one_cycle);
    logic got;
    q3.push_back(exp_t'{chk: !wr, data: exp_rd});
    b3.slv_en = 1'b1; b3.slv_wr = wr; b3.slv_addr = addr;
    b3.slv_wdata = wdata; b3.slv_strb = strb;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge aclk); #1;
      lat++;
      if (b3.slv_ready) got = 1'b1;
    end
    b3.slv_en = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL dut3_timeout: ready=0 after %0d cycles required a pulse", lat);
    end
    @(posedge aclk); #1;
    one_cycle = !b3.slv_ready;
  endtask

  task automatic m1_req(input logic [15:0] addr, input logic [31:0] exp_rd, output int lat);
    logic got;
    q1.push_back(exp_t'{chk: 1'b1, data: exp_rd});
    b1.slv_en = 1'b1; b1.slv_wr = 1'b0; b1.slv_addr = addr;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge aclk); #1;
      lat++;
      if (b1.slv_ready) got = 1'b1;
    end
    b1.slv_en = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL dut1_timeout: ready=0 after %0d cycles required a pulse", lat);
    end
    @(posedge aclk); #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    int lat; logic one;
    chk32("reset_gpio_out", gpio_out3, 32'h0);
    chk32("reset_gpio_oe", gpio_oe3, 32'h0);
    chk32("reset_ready", {31'b0, b3.slv_ready}, 32'h0);
    chk32("reset_rdata", b3.slv_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      m3_req(1'b0, 16'h100 + 16'(4 * i), 32'h0, 4'h0, 32'h0, lat, one);
      chk32("reset_read_one_pulse", {31'b0, one}, 32'h1);
    end
  endtask

  task automatic test_write_latency();
    int lat; logic one;
    m3_req(1'b1, 16'h100, 32'hA5A5_1234, 4'b0101, 32'h0, lat, one);
    chk32("write_latency", 32'(lat), 32'd3);
    chk32("write_one_pulse", {31'b0, one}, 32'h1);
    chk32("write_strb_out", gpio_out3, 32'h00A5_0034);
    m3_req(1'b0, 16'h100, 32'h0, 4'h0, 32'h00A5_0034, lat, one);
    m3_req(1'b1, 16'h104, 32'hFFFF_0000, 4'b1100, 32'h0, lat, one);
    chk32("write_oe", gpio_oe3, 32'hFFFF_0000);
  endtask

  task automatic test_input_sync();
    int lat; logic one;
    gpio_in3 = 32'h0000_0081;
    m3_req(1'b0, 16'h108, 32'h0, 4'h0, 32'h81, lat, one);
    m3_req(1'b0, 16'h10C, 32'h0, 4'h0, 32'h81, lat, one);
    m3_req(1'b1, 16'h10C, 32'h1, 4'hF, 32'h0, lat, one);
    m3_req(1'b0, 16'h10C, 32'h0, 4'h0, 32'h80, lat, one);
  endtask

  task automatic test_set_wins();
    int lat; logic one;
    gpio_in3 = 32'h0000_0080;
    repeat (4) @(posedge aclk);
    #1;
    // Bit 0 rises in the very cycle whose closing edge commits the clear.
    fork
      m3_req(1'b1, 16'h10C, 32'h1, 4'hF, 32'h0, lat, one);
      begin
        @(posedge aclk); #1;
        gpio_in3 = 32'h0000_0081;
      end
    join
    m3_req(1'b0, 16'h10C, 32'h0, 4'h0, 32'h81, lat, one);
  endtask

  task automatic test_out_of_range();
    int lat; logic one;
    m3_req(1'b0, 16'h120, 32'h0, 4'h0, 32'h0, lat, one);
    chk32("oor_read_latency", 32'(lat), 32'd3);
    m3_req(1'b0, 16'h0F0, 32'h0, 4'h0, 32'h0, lat, one);
    m3_req(1'b1, 16'h114, 32'hFFFF_FFFF, 4'hF, 32'h0, lat, one);
    chk32("oor_write_out", gpio_out3, 32'h00A5_0034);
    chk32("oor_write_oe", gpio_oe3, 32'hFFFF_0000);
  endtask

  task automatic test_reset_wait();
    int lat; logic one; logic saw;
    b3.slv_en = 1'b1; b3.slv_wr = 1'b1; b3.slv_addr = 16'h100;
    b3.slv_wdata = 32'hFFFF_FFFF; b3.slv_strb = 4'hF;
    @(posedge aclk); @(posedge aclk); #1;
    aresetn3 = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge aclk); #1;
      if (b3.slv_ready) saw = 1'b1;
    end
    b3.slv_en = 1'b0;
    aresetn3 = 1'b1;
    chk32("areset_no_ready", {31'b0, saw}, 32'h0);
    chk32("areset_out", gpio_out3, 32'h0);
    chk32("areset_oe", gpio_oe3, 32'h0);
    m3_req(1'b0, 16'h100, 32'h0, 4'h0, 32'h0, lat, one);
  endtask

  task automatic test_srst_write();
    int lat; logic one; logic saw;
    m3_req(1'b1, 16'h100, 32'h1122_3344, 4'hF, 32'h0, lat, one);
    chk32("srst_pre_out", gpio_out3, 32'h1122_3344);
    b3.slv_en = 1'b1; b3.slv_wr = 1'b1; b3.slv_addr = 16'h100;
    b3.slv_wdata = 32'hFFFF_FFFF; b3.slv_strb = 4'hF;
    @(posedge aclk); #1;
    srst3 = 1'b1;
    @(posedge aclk); #1;
    srst3 = 1'b0;
    b3.slv_en = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge aclk); #1;
      if (b3.slv_ready) saw = 1'b1;
    end
    chk32("srst_no_ready", {31'b0, saw}, 32'h0);
    chk32("srst_out_not_written", gpio_out3, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen, exp_pat;
    exp_pat = 4'b0101;
    q1.push_back(exp_t'{chk: 1'b1, data: 32'h1234_5678});
    q1.push_back(exp_t'{chk: 1'b1, data: 32'h0});
    b1.slv_en = 1'b1; b1.slv_wr = 1'b0; b1.slv_addr = 16'h8;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      seen[i] = b1.slv_ready;
      if (i == 0) b1.slv_addr = 16'h4;
      if (i == 2) b1.slv_en = 1'b0;
    end
    chk32("b2b_ready_pattern", {28'b0, seen}, {28'b0, exp_pat});
  endtask

  task automatic test_sync_delay();
    int lat;
    gpio_in1 = 32'hFFFF_0000;
    m1_req(16'h8, 32'h1234_5678, lat);
    chk32("sync_latency1", 32'(lat), 32'd1);
    repeat (3) @(posedge aclk);
    #1;
    m1_req(16'h8, 32'hFFFF_0000, lat);
  endtask

  initial begin
    aresetn3 = 1'b0; aresetn1 = 1'b0; srst3 = 1'b0; srst1 = 1'b0;
    gpio_in3 = 32'h0; gpio_in1 = 32'h1234_5678;
    b3.slv_en = 1'b0; b3.slv_wr = 1'b0; b3.slv_addr = '0; b3.slv_wdata = '0; b3.slv_strb = '0;
    b1.slv_en = 1'b0; b1.slv_wr = 1'b0; b1.slv_addr = '0; b1.slv_wdata = '0; b1.slv_strb = '0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn3 = 1'b1; aresetn1 = 1'b1;
    @(posedge aclk); #1;
    test_reset();
    test_write_latency();
    test_input_sync();
    test_set_wins();
    test_out_of_range();
    test_reset_wait();
    test_srst_write();
    test_back_to_back();
    test_sync_delay();
    repeat (3) @(posedge aclk);
    #1;
    chk32("dut3_queue_drained", 32'(q3.size()), 32'd0);
    chk32("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/friscv_gpio_responder.md
Name: friscv_gpio_responder

Overview:
- Slave-side responder for the core's en/wr/addr/wdata/strb/rdata/ready memory interface. It sits behind the memory router's GPIO port.
- Implements a small GPIO register bank: output data, output enable, synchronized input, and a sticky rising-edge status.
- Every accepted request completes with exactly one ready pulse after a programmable latency.

Parameters:
- ADDRW, 16, address width of the slave interface.
- XLEN, 32, data width; also the number of GPIO pins.
- GPIO_BASE_ADDR, 0, base address of the register window; register offsets are relative to it.
- LATENCY, 1, cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous active-high reset; same effect as aresetn
- slv_en  in  1  request valid; the master holds it until slv_ready
- slv_wr  in  1  1 = write, 0 = read
- slv_addr  in  ADDRW  byte address
- slv_wdata  in  XLEN  write data
- slv_strb  in  XLEN/8  write byte enables
- slv_rdata  out  XLEN  read data; valid only while slv_ready=1
- slv_ready  out  1  one-cycle completion pulse
- gpio_in  in  XLEN  asynchronous pad inputs
- gpio_out  out  XLEN  OUT register
- gpio_oe  out  XLEN  OE register, 1 = drive

Behaviour:
- Reset (aresetn low, or srst high at a clock edge):
  - OUT, OE, RISE, both sync stages and the previous-value register all clear to 0.
  - FSM goes to IDLE and the latency counter clears to 0.
  - slv_ready=0, slv_rdata=0, gpio_out=0, gpio_oe=0.
- Register map: off = slv_addr - GPIO_BASE_ADDR, word-aligned; slv_addr[1:0] is ignored.
  - 0x0 OUT: read/write.
  - 0x4 OE: read/write.
  - 0x8 IN: read-only; returns the 2-flop synchronized gpio_in; writes are ignored.
  - 0xC RISE: sticky; a bit sets on a 0->1 transition of its synchronized input; write-1-to-clear.
  - off >= 0x10, or slv_addr < GPIO_BASE_ADDR: reads return 0, writes are ignored, ready is still returned (no bus hang).
- Writes: byte lane k updates only if slv_strb[k]=1. For RISE, strobe-qualified wdata bits clear the corresponding status bits.
- Input path:
  - sync1 <= gpio_in; sync2 <= sync1; prev <= sync2.
  - rise_evt = sync2 & ~prev.
  - When rise_evt and a write-1-to-clear hit the same bit in the same cycle, set wins.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if slv_en=1, capture wr/addr/wdata/strb and load cnt = LATENCY-1. Go to RESP if LATENCY=1, otherwise to WAIT.
  - WAIT: decrement cnt each cycle; go to RESP when cnt reaches 1.
  - RESP: drive slv_ready=1 for exactly one cycle.
    - Writes commit to the registers on this cycle's edge.
    - Reads are sampled at the RESP-entry edge and held on slv_rdata during RESP.
    - Next state is always IDLE.
  - slv_ready is registered, never combinational from slv_en.
  - Total latency = LATENCY cycles from the accept edge to the first ready-high edge.
- The request is not re-sampled during WAIT or RESP. slv_en still high on the cycle after RESP is treated as a new request, so the minimum back-to-back throughput is one transaction per LATENCY+1 cycles.
- slv_rdata is 0 whenever slv_ready=0.
- Reset mid-transaction: the transaction is dropped, no ready pulse is issued, and no register is modified.
- Input sync runs continuously, independent of the FSM state.

Test Plan:
- Reset release; read 0x0, 0x4, 0x8 with gpio_in=0 -> rdata=0 each time, one ready pulse per access, gpio_out=gpio_oe=0.
- LATENCY=3:
  - Write 0x0 = 0xA5A5_1234, strb=4'b0101 -> gpio_out=0x00A5_0034.
  - slv_ready rises exactly 3 cycles after the accept edge and is high for exactly 1 cycle.
- gpio_in steps 0 -> 0x0000_0081 -> read 0x8 returns 0x81 no earlier than 2 cycles later; RISE=0x81.
  - Write 0xC = 0x01 -> RISE=0x80.
- Same-cycle pulse on gpio_in bit 0 and W1C of bit 0 -> RISE bit 0 stays 1.
- Read at off 0x20 -> rdata=0 with a ready pulse; write 0x14 = 0xFFFFFFFF -> no register changes.
- Reset:
  - aresetn asserted during WAIT -> no ready pulse, registers 0.
  - srst mid-write -> OUT is unchanged by the aborted write.
- slv_en held high across two back-to-back reads (LATENCY=1) -> ready pulses on cycles 1 and 3, with correct data on each.
